// File: rtl/cache_mem_arbiter_if.sv
// Shared-RAM bus bundle for cache_mem_arbiter: icache, dcache and RAM sides.
// slave is the arbiter's view; master is the caches'/RAM's view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic              dlock;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  logic              ram_ack;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, dlock, daddr, dstore, ramload, ram_ack,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, dlock, daddr, dstore, ramload, ram_ack,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one RAM port between icache and dcache: dcache priority, lock, anti-starvation.
// Define ARB_PERF_EN to add the icount/dcount/scount performance counters.
module cache_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  cache_mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]        icount,
  output logic [31:0]        dcount,
  output logic [31:0]        scount
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_LIM   = LW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [SW-1:0] r_starveCnt;
  logic [SW-1:0] w_starveNext;
  logic [LW-1:0] r_lockCnt;
  logic [LW-1:0] w_lockNext;

  logic w_dReq;
  logic w_iDone;
  logic w_dDone;
  logic w_abort;
  logic w_arbitrate;

  // A completion only counts while the granted side still drives its request.
  always_comb begin
    w_dReq      = bus.dREN | bus.dWEN;
    w_iDone     = (r_state == IACC) & bus.iREN & bus.ram_ack;
    w_dDone     = (r_state == DACC) & w_dReq & bus.ram_ack;
    w_abort     = ((r_state == IACC) & ~bus.iREN) | ((r_state == DACC) & ~w_dReq);
    w_arbitrate = (r_state == IDLE) | w_iDone | w_dDone;
  end

  // The starvation test uses the post-update count so the forced fetch follows the Nth dcache word directly.
  always_comb begin
    w_starveNext = r_starveCnt;
    if (!bus.iREN || w_iDone) begin
      w_starveNext = '0;
    end else if (w_dDone && (r_starveCnt < STARVE_LIM)) begin
      w_starveNext = r_starveCnt + SW'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_abort) begin
      w_nextState = IDLE;
    end else if (w_arbitrate) begin
      if ((r_state == DACC) && bus.dlock && w_dReq && (r_lockCnt < LOCK_LIM)) begin
        w_nextState = DACC;
      end else if (bus.iREN && (w_starveNext == STARVE_LIM)) begin
        w_nextState = IACC;
      end else if (w_dReq) begin
        w_nextState = DACC;
      end else if (bus.iREN) begin
        w_nextState = IACC;
      end else begin
        w_nextState = IDLE;
      end
    end
  end

  always_comb begin
    w_lockNext = r_lockCnt;
    if (w_dDone) begin
      if (!bus.dlock) begin
        w_lockNext = '0;
      end else if (r_lockCnt < LOCK_LIM) begin
        w_lockNext = r_lockCnt + LW'(1);
      end
    end else if (w_iDone && !bus.dlock) begin
      w_lockNext = '0;
    end
    if ((r_state == DACC) && (w_nextState != DACC)) begin
      w_lockNext = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_starveCnt <= '0;
      r_lockCnt   <= '0;
    end else begin
      r_state     <= w_nextState;
      r_starveCnt <= w_starveNext;
      r_lockCnt   <= w_lockNext;
    end
  end

  // RAM side sees only the granted requester; wait flags drop only on a real completion.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    case (r_state)
      IACC: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = ~w_iDone;
        bus.iload   = bus.ramload;
      end
      DACC: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = ~w_dDone;
        bus.dload    = bus.ramload;
      end
      default: begin
        bus.ramREN = 1'b0;
      end
    endcase
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
      scount <= '0;
    end else begin
      if (w_iDone) icount <= icount + 32'd1;
      if (w_dDone) dcount <= dcount + 32'd1;
      if (bus.iREN && (r_state != IACC)) scount <= scount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs driven 1 time unit after posedge, outputs checked on negedge.
// With ARB_PERF_EN defined the performance counters are also checked.
module tb_cache_mem_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   compareCount  = 0;
  int   mismatchCount = 0;

  cache_mem_arbiter_if bus ();

`ifdef ARB_PERF_EN
  logic [31:0] icount;
  logic [31:0] dcount;
  logic [31:0] scount;
`endif

  cache_mem_arbiter dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus    (bus)
`ifdef ARB_PERF_EN
    ,
    .icount (icount),
    .dcount (dcount),
    .scount (scount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iren, input logic [31:0] iaddr,
                               input logic dren, input logic dwen, input logic dlock,
                               input logic [31:0] daddr, input logic [31:0] dstore,
                               input logic ack, input logic [31:0] ramload);
    bus.iREN    = iren;
    bus.iaddr   = iaddr;
    bus.dREN    = dren;
    bus.dWEN    = dwen;
    bus.dlock   = dlock;
    bus.daddr   = daddr;
    bus.dstore  = dstore;
    bus.ram_ack = ack;
    bus.ramload = ramload;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  initial begin
    // Reset with every request active: outputs must still be idle.
    RST = 1'b1;
    applyStimulus(1, 32'h40, 1, 1, 1, 32'h100, 32'h55, 1, 32'hFFFF_FFFF);
    sample();
    checkOutput("reset_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    checkOutput("reset_ramWEN",   {31'd0, bus.ramWEN}, 32'd0);
    checkOutput("reset_ramaddr",  bus.ramaddr,         32'd0);
    checkOutput("reset_ramstore", bus.ramstore,        32'd0);
    checkOutput("reset_iwait",    {31'd0, bus.iwait},  32'd1);
    checkOutput("reset_dwait",    {31'd0, bus.dwait},  32'd1);
    checkOutput("reset_iload",    bus.iload,           32'd0);
    checkOutput("reset_dload",    bus.dload,           32'd0);
    nextCycle();
    RST = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Icache alone: grant one cycle after request, ack on the second IACC cycle.
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h8C01_0004);
    sample();
    checkOutput("ic_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    nextCycle();
    sample();
    checkOutput("ic_ramREN",     {31'd0, bus.ramREN}, 32'd1);
    checkOutput("ic_ramaddr",    bus.ramaddr,         32'h40);
    checkOutput("ic_iwait_busy", {31'd0, bus.iwait},  32'd1);
    nextCycle();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h8C01_0004);
    sample();
    checkOutput("ic_iwait_ack", {31'd0, bus.iwait}, 32'd0);
    checkOutput("ic_iload",     bus.iload,          32'h8C01_0004);
    checkOutput("ic_dwait",     {31'd0, bus.dwait}, 32'd1);
    nextCycle();
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("ic_post_ramREN", {31'd0, bus.ramREN}, 32'd0);
    checkOutput("ic_post_iwait",  {31'd0, bus.iwait},  32'd1);
    nextCycle();

    // Contention: dcache wins, then dREN drops before the next ack (abort), then icache.
    applyStimulus(1, 32'h80, 1, 0, 0, 32'h100, 0, 0, 0);
    sample();
    checkOutput("ct_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    nextCycle();
    applyStimulus(1, 32'h80, 1, 0, 0, 32'h100, 0, 1, 32'h1111_2222);
    sample();
    checkOutput("ct_ramaddr", bus.ramaddr,         32'h100);
    checkOutput("ct_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    checkOutput("ct_dwait",   {31'd0, bus.dwait},  32'd0);
    checkOutput("ct_dload",   bus.dload,           32'h1111_2222);
    checkOutput("ct_iwait",   {31'd0, bus.iwait},  32'd1);
    nextCycle();
    applyStimulus(1, 32'h80, 0, 0, 0, 32'h100, 0, 1, 0);
    sample();
    checkOutput("ab_ramREN", {31'd0, bus.ramREN}, 32'd0);
    checkOutput("ab_dwait",  {31'd0, bus.dwait},  32'd1);
    nextCycle();
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("ab_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    nextCycle();
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h3333_4444);
    sample();
    checkOutput("ct_i_ramaddr", bus.ramaddr,        32'h80);
    checkOutput("ct_i_iwait",   {31'd0, bus.iwait}, 32'd0);
    checkOutput("ct_i_iload",   bus.iload,          32'h3333_4444);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Locked block: two writebacks then two fills, icache waiting throughout.
    applyStimulus(1, 32'h44, 0, 1, 1, 32'h200, 32'hAAAA_0000, 0, 0);
    sample();
    checkOutput("lk_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    nextCycle();
    applyStimulus(1, 32'h44, 0, 1, 1, 32'h200, 32'hAAAA_0000, 1, 0);
    sample();
    checkOutput("lk_w0_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    checkOutput("lk_w0_ramaddr",  bus.ramaddr,         32'h200);
    checkOutput("lk_w0_ramstore", bus.ramstore,        32'hAAAA_0000);
    checkOutput("lk_w0_dwait",    {31'd0, bus.dwait},  32'd0);
    nextCycle();
    applyStimulus(1, 32'h44, 1, 1, 1, 32'h204, 32'hAAAA_0004, 1, 0);
    sample();
    checkOutput("lk_w1_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    checkOutput("lk_w1_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    checkOutput("lk_w1_ramaddr",  bus.ramaddr,         32'h204);
    checkOutput("lk_w1_ramstore", bus.ramstore,        32'hAAAA_0004);
    nextCycle();
    applyStimulus(1, 32'h44, 1, 0, 1, 32'h300, 0, 1, 32'h30);
    sample();
    checkOutput("lk_r0_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    checkOutput("lk_r0_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
    checkOutput("lk_r0_ramaddr", bus.ramaddr,         32'h300);
    checkOutput("lk_r0_dload",   bus.dload,           32'h30);
    nextCycle();
    applyStimulus(1, 32'h44, 1, 0, 0, 32'h304, 0, 1, 32'h34);
    sample();
    checkOutput("lk_r1_ramaddr", bus.ramaddr,        32'h304);
    checkOutput("lk_r1_dload",   bus.dload,          32'h34);
    checkOutput("lk_r1_iwait",   {31'd0, bus.iwait}, 32'd1);
    nextCycle();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("lk_i_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    checkOutput("lk_i_ramaddr", bus.ramaddr,         32'h44);
    nextCycle();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 1, 32'h4444);
    sample();
    checkOutput("lk_i_iwait", {31'd0, bus.iwait}, 32'd0);
    checkOutput("lk_i_iload", bus.iload,          32'h4444);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Reset asserted mid-IACC takes effect without a clock edge.
    applyStimulus(1, 32'h4C, 0, 0, 0, 0, 0, 0, 32'h5A5A_5A5A);
    nextCycle();
    sample();
    checkOutput("rs_pre_ramREN", {31'd0, bus.ramREN}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rs_ramREN",  {31'd0, bus.ramREN}, 32'd0);
    checkOutput("rs_iwait",   {31'd0, bus.iwait},  32'd1);
    checkOutput("rs_iload",   bus.iload,           32'd0);
    checkOutput("rs_ramaddr", bus.ramaddr,         32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    RST = 1'b0;
    nextCycle();

    // Starvation: dREN held with dlock=0; icache forced in after exactly four dcache words.
    applyStimulus(1, 32'h48, 1, 0, 0, 32'h400, 0, 0, 0);
    sample();
    checkOutput("sv_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(1, 32'h48, 1, 0, 0, 32'h400, 0, 1, 32'h400 + 32'(k));
      sample();
      checkOutput($sformatf("sv_d%0d_ramaddr", k), bus.ramaddr,        32'h400);
      checkOutput($sformatf("sv_d%0d_dload", k),   bus.dload,          32'h400 + 32'(k));
      checkOutput($sformatf("sv_d%0d_iwait", k),   {31'd0, bus.iwait}, 32'd1);
    end
    nextCycle();
    applyStimulus(1, 32'h48, 1, 0, 0, 32'h400, 0, 0, 0);
    sample();
    checkOutput("sv_i_ramaddr", bus.ramaddr,         32'h48);
    checkOutput("sv_i_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    checkOutput("sv_i_dwait",   {31'd0, bus.dwait},  32'd1);
    nextCycle();
    applyStimulus(1, 32'h48, 1, 0, 0, 32'h400, 0, 1, 32'h4848);
    sample();
    checkOutput("sv_i_iwait", {31'd0, bus.iwait}, 32'd0);
    checkOutput("sv_i_iload", bus.iload,          32'h4848);
    nextCycle();
    // Starve count cleared by the icache ack, so the dcache gets the bus back despite iREN.
    applyStimulus(0, 32'h48, 1, 0, 0, 32'h400, 0, 0, 0);
    sample();
    checkOutput("sv_back_ramaddr", bus.ramaddr,         32'h400);
    checkOutput("sv_back_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("sv_end_ramREN", {31'd0, bus.ramREN}, 32'd0);
    nextCycle();
    sample();
`ifdef ARB_PERF_EN
    checkOutput("perf_icount", icount, 32'd1);
    checkOutput("perf_dcount", dcount, 32'd4);
    checkOutput("perf_scount", scount, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
